// File: rtl/therm_pkg.sv
// therm_pkg: shared defaults, level-width helper and filter state type
// for the thermometer level filter.
`default_nettype none

package therm_pkg;

  localparam int DEFAULT_N      = 5;
  localparam int DEFAULT_STABLE = 3;
  localparam int CNT_W          = 4;

  function automatic int level_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } filt_state_t;

endpackage

`default_nettype wire

// File: rtl/therm_decode.sv
// therm_decode: thermometer-to-binary decode with bubble detection and
// the stage-1 register (one cycle latency).
`default_nettype none

module therm_decode
  import therm_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N-1:0]              in_therm,
  output logic                      s1_valid,
  output logic [level_width(N)-1:0] s1_level,
  output logic                      s1_legal
);

  localparam int CW = level_width(N);

  logic [CW-1:0] dec_level;
  logic          dec_legal;

  // Level is the position of the lowest set bit; all-zero reads as N.
  always_comb begin
    dec_level = CW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (in_therm[i]) begin
        dec_level = CW'(i);
      end
    end
  end

  // A legal code has no zero at or above the decoded level.
  always_comb begin
    dec_legal = 1'b1;
    for (int i = 0; i < N; i++) begin
      if ((CW'(i) >= dec_level) && !in_therm[i]) begin
        dec_legal = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_level <= '0;
      s1_legal <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_level <= dec_level;
      s1_legal <= dec_legal;
    end
  end

endmodule

`default_nettype wire

// File: rtl/therm_level_filter.sv
// therm_level_filter: decodes and debounces a thermometer level, reporting each
// new level on a valid/ready output. Define THERM_ERR_CNT_EN to add err_count.
`default_nettype none

module therm_level_filter
  import therm_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STABLE = DEFAULT_STABLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N-1:0]              in_therm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [level_width(N)-1:0] out_level,
  output logic                      out_err
`ifdef THERM_ERR_CNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  localparam int                CW       = level_width(N);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

  logic          s1_valid;
  logic [CW-1:0] s1_level;
  logic          s1_legal;

  therm_decode #(
    .N (N)
  ) u_decode (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_therm (in_therm),
    .s1_valid (s1_valid),
    .s1_level (s1_level),
    .s1_legal (s1_legal)
  );

  filt_state_t      state;
  filt_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CW-1:0]    cand;
  logic [CW-1:0]    cand_next;
  logic [CW-1:0]    rep_level;
  logic             rep_vld;
  logic             sample_bad;
  logic             qualify;
  logic             emit;

  assign sample_bad = s1_valid && !s1_legal;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    if (s1_valid) begin
      if (!s1_legal) begin
        cnt_next   = '0;
        state_next = ACQUIRE;
      end else begin
        if ((s1_level == cand) && (cnt != '0)) begin
          cnt_next = (cnt >= STABLE_C) ? STABLE_C : cnt + 1'b1;
        end else begin
          cand_next = s1_level;
          cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
        end
        state_next = (cnt_next == STABLE_C) ? LOCKED : ACQUIRE;
      end
    end
  end

  // Once locked, repeats of the reported level are suppressed via rep_level.
  assign qualify = s1_valid && s1_legal && (cnt_next == STABLE_C);
  assign emit    = qualify && (!rep_vld || (cand_next != rep_level));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACQUIRE;
      cnt       <= '0;
      cand      <= '0;
      rep_level <= '0;
      rep_vld   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
      if (emit) begin
        rep_level <= cand_next;
        rep_vld   <= 1'b1;
      end
    end
  end

  // Latest emission wins over an unaccepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_level <= '0;
      out_err   <= 1'b0;
    end else begin
      out_err <= sample_bad;
      if (emit) begin
        out_valid <= 1'b1;
        out_level <= cand_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef THERM_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (sample_bad && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_therm_level_filter.sv
// Directed bench for therm_level_filter with an emission/error scoreboard.
`default_nettype none

module tb_therm_level_filter;

  localparam int N  = 5;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [N-1:0]  in_therm;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_level;
  logic          out_err;
`ifdef THERM_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  therm_level_filter #(
    .N      (N),
    .STABLE (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_therm  (in_therm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level),
    .out_err   (out_err)
`ifdef THERM_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int err_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive a sample, score any acceptance at the coming edge,
  // then check out_err against the expected error cycles.
  task automatic step(input logic v, input logic [N-1:0] t);
    logic exp_err;
    in_valid = v;
    in_therm = t;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL emit_unexpected observed level=%0d expected none", out_level);
      end
      if (exp_q.size() != 0) chk("emit_level", 32'(out_level), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
    chk("out_err", 32'(out_err), 32'(exp_err));
    if (exp_err) void'(err_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_therm = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    err_q.delete();
    cyc = 0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_therm  = '0;
    out_ready = 1'b1;
    do_reset();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_level", 32'(out_level), 32'd0);
    chk("reset_err", 32'(out_err), 32'd0);
`ifdef THERM_ERR_CNT_EN
    chk("reset_err_count", 32'(err_count), 32'd0);
`endif

    // Level 2 qualifies after three samples, visible at cycle 4 only.
    exp_q.push_back(2);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    chk("t1_valid_c3", 32'(out_valid), 32'd0);
    step(1'b1, 5'b11100);
    chk("t1_valid_c4", 32'(out_valid), 32'd1);
    chk("t1_level_c4", 32'(out_level), 32'd2);
    step(1'b1, 5'b11100);
    chk("t1_valid_c5", 32'(out_valid), 32'd0);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    idle(2);
    chk("t1_no_reemit", 32'(out_valid), 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // All-zero then all-one codes.
    exp_q.push_back(5);
    for (int k = 0; k < 3; k++) step(1'b1, 5'b00000);
    exp_q.push_back(0);
    for (int k = 0; k < 3; k++) step(1'b1, 5'b11111);
    idle(3);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Bubble breaks the run; err at cycle 4.
    do_reset();
    err_q.push_back(4);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b10100);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    idle(2);
    chk("t3_no_emit", 32'(out_valid), 32'd0);
    exp_q.push_back(2);
    step(1'b1, 5'b11100);
    idle(2);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_err_q_empty", 32'(err_q.size()), 32'd0);
`ifdef THERM_ERR_CNT_EN
    chk("t3_err_count", 32'(err_count), 32'd1);
`endif

    // Back-pressure: latest level overwrites the pending one.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(4);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b11100);
    step(1'b1, 5'b10000);
    chk("t4_valid_l2", 32'(out_valid), 32'd1);
    chk("t4_level_l2", 32'(out_level), 32'd2);
    step(1'b1, 5'b10000);
    step(1'b1, 5'b10000);
    idle(1);
    chk("t4_valid_l4", 32'(out_valid), 32'd1);
    chk("t4_level_l4", 32'(out_level), 32'd4);
    idle(1);
    chk("t4_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("t4_cleared", 32'(out_valid), 32'd0);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Gaps do not break a run.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(3);
    step(1'b1, 5'b11000);
    idle(1);
    step(1'b1, 5'b11000);
    idle(1);
    step(1'b1, 5'b11000);
    chk("t5_valid_c5", 32'(out_valid), 32'd0);
    idle(1);
    chk("t5_valid_c6", 32'(out_valid), 32'd1);
    chk("t5_level_c6", 32'(out_level), 32'd3);
    idle(1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset drops a pending level; the level re-emits afterwards.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(2);
    for (int k = 0; k < 3; k++) step(1'b1, 5'b11100);
    idle(2);
    chk("t6_pending", 32'(out_valid), 32'd1);
    step(1'b1, 5'b11000);
    step(1'b1, 5'b11000);
    rst = 1'b1;
    #2;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_level", 32'(out_level), 32'd0);
    chk("t6_async_err", 32'(out_err), 32'd0);
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(2);
    for (int k = 0; k < 3; k++) step(1'b1, 5'b11100);
    idle(1);
    chk("t6_reemit_valid", 32'(out_valid), 32'd1);
    chk("t6_reemit_level", 32'(out_level), 32'd2);
    idle(1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
